// File: rtl/sweep_sequencer.sv
// Sweep sequencer: steps frequency x tx-port x rx-port, settles the source and averages NAVG probe samples per S-parameter.
// Optional abort/aborted ports are present only when SWEEP_ABORT_EN is defined.
module sweep_sequencer #(
    parameter int NPORT  = 2,
    parameter int NPTS   = 16,
    parameter int DW     = 16,
    parameter int SETTLE = 8,
    parameter int NAVG   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
`ifdef SWEEP_ABORT_EN
    input  logic                                      abort,
    output logic                                      aborted,
`endif
    output logic                                      busy,
    output logic                                      done,
    output logic [((NPTS > 1) ? $clog2(NPTS) : 1)-1:0] freq_idx,
    output logic                                      src_en,
    output logic [$clog2(NPORT)-1:0]                  src_port,
    output logic [$clog2(NPORT)-1:0]                  probe_sel,
    input  logic                                      probe_valid,
    input  logic signed [DW-1:0]                      probe_data,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic signed [DW-1:0]                      res_data,
    output logic [$clog2(NPORT)-1:0]                  res_tx,
    output logic [$clog2(NPORT)-1:0]                  res_rx
);

    localparam int FW = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int PW = $clog2(NPORT);
    localparam int SH = $clog2(NAVG);
    localparam int AW = DW + SH;
    localparam int CW = (NAVG > 1) ? $clog2(NAVG) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;

    localparam logic [FW-1:0] F_LAST = FW'(NPTS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NPORT - 1);
    localparam logic [CW-1:0] N_LAST = CW'(NAVG - 1);
    localparam logic [7:0]    S_LAST = 8'(SETTLE - 1);
    // A zero settle time skips the SETTLE state entirely after a source change.
    localparam logic [2:0]    S_AFTER_SRC = (SETTLE == 0) ? S_MEASURE : S_SETTLE;

    logic [2:0]           state;
    logic [7:0]           settle_cnt;
    logic [CW-1:0]        avg_cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    logic signed [DW-1:0] res_next;

    assign acc_sum  = acc + AW'(probe_data);
    assign res_next = DW'(acc_sum >>> SH);

    assign busy      = (state != S_IDLE);
    assign src_en    = busy;
    assign res_valid = (state == S_EMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            freq_idx   <= '0;
            src_port   <= '0;
            probe_sel  <= '0;
            settle_cnt <= '0;
            avg_cnt    <= '0;
            acc        <= '0;
            res_data   <= '0;
            res_tx     <= '0;
            res_rx     <= '0;
`ifdef SWEEP_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SWEEP_ABORT_EN
            aborted <= 1'b0;
            // Abort overrides every state transition below except in IDLE.
            if (abort && (state != S_IDLE)) begin
                state   <= S_IDLE;
                aborted <= 1'b1;
            end else
`endif
            case (state)
                S_IDLE: begin
                    if (start && !done) begin
                        freq_idx   <= '0;
                        src_port   <= '0;
                        probe_sel  <= '0;
                        settle_cnt <= '0;
                        avg_cnt    <= '0;
                        acc        <= '0;
                        state      <= S_AFTER_SRC;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == S_LAST) begin
                        state <= S_MEASURE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                S_MEASURE: begin
                    if (probe_valid) begin
                        acc <= acc_sum;
                        if (avg_cnt == N_LAST) begin
                            res_data <= res_next;
                            res_tx   <= src_port;
                            res_rx   <= probe_sel;
                            avg_cnt  <= '0;
                            state    <= S_EMIT;
                        end else begin
                            avg_cnt <= avg_cnt + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    acc        <= '0;
                    avg_cnt    <= '0;
                    settle_cnt <= '0;
                    if (probe_sel != P_LAST) begin
                        probe_sel <= probe_sel + 1'b1;
                        state     <= S_MEASURE;
                    end else begin
                        probe_sel <= '0;
                        if (src_port != P_LAST) begin
                            src_port <= src_port + 1'b1;
                            state    <= S_AFTER_SRC;
                        end else if (freq_idx != F_LAST) begin
                            src_port <= '0;
                            freq_idx <= freq_idx + 1'b1;
                            state    <= S_AFTER_SRC;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer at default parameters: averaging vectors, EMIT stall,
// full-sweep ordering/timing, mid-sweep reset and (with SWEEP_ABORT_EN) abort.
module tb_sweep_sequencer;

    localparam int SETTLE = 8;
    localparam logic signed [15:0] GARB = 16'sh7000;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic [3:0]         freq_idx;
    logic               src_en;
    logic [0:0]         src_port;
    logic [0:0]         probe_sel;
    logic               probe_valid;
    logic signed [15:0] probe_data;
    logic               res_valid;
    logic               res_ready;
    logic signed [15:0] res_data;
    logic [0:0]         res_tx;
    logic [0:0]         res_rx;
`ifdef SWEEP_ABORT_EN
    logic               abort;
    logic               aborted;
`endif

    int n_checks;
    int n_err;

    sweep_sequencer #(
        .NPORT (2),
        .NPTS  (16),
        .DW    (16),
        .SETTLE(SETTLE),
        .NAVG  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SWEEP_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .busy       (busy),
        .done       (done),
        .freq_idx   (freq_idx),
        .src_en     (src_en),
        .src_port   (src_port),
        .probe_sel  (probe_sel),
        .probe_valid(probe_valid),
        .probe_data (probe_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tx     (res_tx),
        .res_rx     (res_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s0, s1, s2, s3;
        int exp;
        int hold;
    } vec_t;

    vec_t tv [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_src_en"},    src_en,    0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_freq_idx"},  freq_idx,  0);
        chk({tag, "_src_port"},  src_port,  0);
        chk({tag, "_probe_sel"}, probe_sel, 0);
        chk({tag, "_res_data"},  res_data,  0);
        chk({tag, "_res_tx"},    res_tx,    0);
        chk({tag, "_res_rx"},    res_rx,    0);
    endtask

    initial begin
        int npre;
        int cyc;
        int prev;
        int nres;
        int last_res;
        int seen;
        bit done_seen;
        bit reached;

        n_checks = 0;
        n_err    = 0;
        rst = 1'b1; start = 1'b1; probe_valid = 1'b0; probe_data = '0; res_ready = 1'b0;
`ifdef SWEEP_ABORT_EN
        abort = 1'b0;
`endif

        tv[0] = '{s0:   100, s1:   100, s2:   100, s3:   100, exp:    100, hold: 0};
        tv[1] = '{s0:    -3, s1:    -2, s2:    -2, s3:    -2, exp:     -3, hold: 0};
        tv[2] = '{s0:     1, s1:     1, s2:     1, s3:     2, exp:      1, hold: 0};
        tv[3] = '{s0:    -1, s1:     0, s2:     0, s3:     0, exp:     -1, hold: 0};
        tv[4] = '{s0: 32767, s1: 32767, s2: 32767, s3: 32767, exp:  32767, hold: 20};
        tv[5] = '{s0:-32768, s1:-32768, s2:-32768, s3:-32768, exp: -32768, hold: 0};
        tv[6] = '{s0:     7, s1:    -7, s2:     3, s3:    -4, exp:     -1, hold: 0};
        tv[7] = '{s0:     5, s1:     6, s2:     7, s3:     8, exp:      6, hold: 0};

        // Reset with start asserted: reset must win.
        step(); step();
        chk_reset_outputs("reset");
        rst = 1'b0; start = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Table-driven averaging; garbage is offered during SETTLE/EMIT/NEXT and must be ignored.
        res_ready = 1'b1; probe_valid = 1'b1; probe_data = GARB; start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_src_en", src_en, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) npre = SETTLE;
            else        npre = 2 + (((k % 2) == 0) ? SETTLE : 0);
            probe_valid = 1'b1; probe_data = GARB;
            repeat (npre) step();
            probe_data = 16'(tv[k].s0); step();
            probe_data = 16'(tv[k].s1); step();
            probe_data = 16'(tv[k].s2); step();
            probe_data = 16'(tv[k].s3); step();
            probe_data = GARB;
            chk($sformatf("vec%0d_valid", k), res_valid, 1);
            chk($sformatf("vec%0d_data", k), res_data, tv[k].exp);
            chk($sformatf("vec%0d_tx", k), res_tx, (k / 2) % 2);
            chk($sformatf("vec%0d_rx", k), res_rx, k % 2);
            chk($sformatf("vec%0d_freq", k), freq_idx, k / 4);
            if (tv[k].hold > 0) begin
                res_ready = 1'b0;
                for (int i = 0; i < tv[k].hold; i++) begin
                    probe_valid = i[0];
                    probe_data  = 16'(-20000 + i * 7);
                    step();
                    chk($sformatf("hold%0d_valid", i), res_valid, 1);
                    chk($sformatf("hold%0d_data", i), res_data, tv[k].exp);
                end
                res_ready = 1'b1; probe_valid = 1'b1; probe_data = GARB;
            end
        end

        // Full sweep, start held high throughout (ignored while busy and in the done cycle).
        rst = 1'b1; step(); rst = 1'b0;
        probe_valid = 1'b1; probe_data = 16'sd100; res_ready = 1'b1; start = 1'b1;
        cyc = 0; prev = 0; nres = 0; last_res = 0; done_seen = 1'b0;
        while (cyc < 5000 && !done_seen) begin
            step();
            cyc++;
            if (res_valid) begin
                chk($sformatf("sweep%0d_data", nres), res_data, 100);
                chk($sformatf("sweep%0d_tx", nres), res_tx, (nres / 2) % 2);
                chk($sformatf("sweep%0d_rx", nres), res_rx, nres % 2);
                chk($sformatf("sweep%0d_freq", nres), freq_idx, nres / 4);
                if (nres == 0) chk("first_result_latency", cyc, 1 + SETTLE + 4);
                if (nres == 1) chk("rx_advance_gap", cyc - prev, 6);
                if (nres == 2) chk("tx_advance_gap", cyc - prev, 6 + SETTLE);
                prev = cyc;
                nres++;
            end
            if (done) begin
                done_seen = 1'b1;
                chk("done_latency", cyc - prev, 2);
                chk("result_count", nres, 64);
                chk("done_busy", busy, 0);
                chk("done_src_en", src_en, 0);
            end
        end
        chk("sweep_done_seen", done_seen, 1);
        step();
        start = 1'b0;
        chk("start_in_done_ignored", busy, 0);
        chk("done_one_cycle", done, 0);

        // Reset mid-MEASURE at freq_idx=5.
        start = 1'b1; step(); start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            step();
            if (freq_idx == 4'd5) reached = 1'b1;
        end
        chk("reach_freq5", reached, 1);
        repeat (SETTLE + 2) step();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk_reset_outputs("midrst");
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) seen++;
        end
        chk("midrst_no_done", seen, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_freq", freq_idx, 0);
        chk("restart_busy", busy, 1);
        repeat (SETTLE + 4) step();
        chk("restart_valid", res_valid, 1);
        chk("restart_data", res_data, 100);
        chk("restart_tx", res_tx, 0);
        chk("restart_rx", res_rx, 0);

`ifdef SWEEP_ABORT_EN
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            step();
            if (freq_idx == 4'd3) reached = 1'b1;
        end
        chk("reach_freq3", reached, 1);
        step(); step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_aborted", aborted, 1);
        chk("abort_src_en", src_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res_valid", res_valid, 0);
        step();
        chk("aborted_one_cycle", aborted, 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (res_valid || done) seen++;
        end
        chk("post_abort_quiet", seen, 0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("idle_abort_ignored", aborted, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 The block SHALL have parameter NPORT, default 2: number of ports, range 2..8.
REQ-002 The block SHALL have parameter NPTS, default 16: frequency points per sweep, range 1..1024.
REQ-003 The block SHALL have parameter DW, default 16: probe and result sample width, signed.
REQ-004 The block SHALL have parameter SETTLE, default 8: settle cycles after each source change, range 0..255.
REQ-005 The block SHALL have parameter NAVG, default 4: samples averaged per result, a power of two, range 1..64.
REQ-006 The block SHALL have port clk, input, 1: the one clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1: begin a sweep.
REQ-009 The block SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-010 The block SHALL have port done, output, 1: one-cycle pulse at sweep completion.
REQ-011 The block SHALL have port freq_idx, output, clog2(NPTS) (min 1): current frequency point.
REQ-012 The block SHALL have port src_en, output, 1: excitation source enable.
REQ-013 The block SHALL have port src_port, output, clog2(NPORT): excited (tx) port.
REQ-014 The block SHALL have port probe_sel, output, clog2(NPORT): receiver (rx) port selected.
REQ-015 The block SHALL have port probe_valid, input, 1: probe_data qualifier.
REQ-016 The block SHALL have port probe_data, input, DW: signed receiver sample.
REQ-017 The block SHALL have ports res_valid, output, 1 and res_ready, input, 1: result handshake.
REQ-018 The block SHALL have port res_data, output, DW: averaged result.
REQ-019 The block SHALL have ports res_tx and res_rx, output, clog2(NPORT) each: S-parameter indices of res_data (S[rx+1,tx+1]).

Function
REQ-020 The FSM SHALL have the states IDLE, SETTLE, MEASURE, EMIT and NEXT.
REQ-021 In IDLE, start=1 SHALL load freq_idx=0, src_port=0, probe_sel=0, and clear the settle counter, and the FSM SHALL enter SETTLE next cycle with busy=1 and src_en=1.
REQ-022 SETTLE SHALL last exactly SETTLE cycles (SETTLE=0: go straight to MEASURE), and probe_valid SHALL be ignored throughout SETTLE.
REQ-023 MEASURE SHALL accumulate probe_data on each probe_valid=1 cycle into a signed accumulator of DW+log2(NAVG) bits, and after the NAVG-th sample the FSM SHALL enter EMIT.
REQ-024 res_data SHALL equal the accumulator arithmetically right-shifted by log2(NAVG) (floor), and NAVG=1 SHALL pass the sample through unchanged.
REQ-025 EMIT SHALL hold res_valid=1 and res_data/res_tx/res_rx stable until res_ready=1, and probe_valid SHALL be ignored while in EMIT.
REQ-026 After a handshake, NEXT SHALL order the loops probe_sel fastest, then src_port, then freq_idx.
REQ-027 NEXT SHALL, when only probe_sel advances, return to MEASURE with no settle and a cleared accumulator.
REQ-028 NEXT SHALL, when src_port or freq_idx advances, return to SETTLE, wrapping inner indices to 0.
REQ-029 After the final result (freq_idx=NPTS-1, src_port=NPORT-1, probe_sel=NPORT-1), the FSM SHALL enter IDLE with done=1 for one cycle, busy=0 and src_en=0.
REQ-030 start SHALL be ignored while busy=1, and start asserted in the cycle done pulses SHALL be ignored.
REQ-031 A sweep SHALL produce exactly NPTS*NPORT*NPORT results.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL enter IDLE and hold busy=0, done=0, src_en=0, res_valid=0, freq_idx=0, src_port=0, probe_sel=0, res_data=0, res_tx=0, res_rx=0, and the accumulator and counters at 0.
REQ-033 rst SHALL take precedence over start, abort and handshakes, and mid-sweep reset SHALL drop any pending result without done.

Configuration
REQ-034 With SWEEP_ABORT_EN defined, the block SHALL add input abort (1 bit) and output aborted (1 bit).
REQ-035 With SWEEP_ABORT_EN defined, abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle with src_en=0, busy=0, res_valid=0, aborted=1 for one cycle and no done pulse, and abort in IDLE SHALL be ignored.
REQ-036 With SWEEP_ABORT_EN undefined, the abort and aborted ports SHALL be absent and a sweep SHALL always run to completion.

Verification
REQ-037 Defaults, res_ready=1, probe_valid=1 always, probe_data=100 -> bench SHALL see 64 results all 100, tx/rx order (0,0),(0,1),(1,0),(1,1) per point, and done after the last.
REQ-038 NAVG=4, samples -3,-2,-2,-2 (sum -9) -> bench SHALL see res_data=-3 (floor).
REQ-039 res_ready held low 20 cycles in EMIT while probe_valid toggles -> bench SHALL see res_valid high and res_data unchanged for 20 cycles, and the next result unaffected by those samples.
REQ-040 SETTLE=8 -> bench SHALL see the first accumulated sample no earlier than 9 cycles after start, and rx-only advances adding no settle cycles.
REQ-041 rst pulsed mid-MEASURE at freq_idx=5 -> bench SHALL see all outputs at reset values next cycle and no done, and a fresh start restarting at freq_idx=0.
REQ-042 With SWEEP_ABORT_EN, abort during SETTLE of point 3 -> bench SHALL see aborted=1 for one cycle, src_en=0, no done, and no further res_valid.
